// File: rtl/i2so_serializer.sv
// rtl/i2so_serializer.sv - I2S output serializer with one-deep stereo holding register
module i2so_serializer #(
    parameter int BPW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sck_fall,
    input  logic           rf_i2so_en,
    input  logic [BPW-1:0] in_lft,
    input  logic [BPW-1:0] in_rgt,
    input  logic           in_xfc,
    output logic           out_sd,
    output logic           out_ws,
    output logic           out_rdy,
    output logic           out_udr,
    output logic           out_ovf
);
    localparam int NS = 2 * BPW;
    localparam int SW = $clog2(NS);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [NS-1:0]   frame_q, frame_d;
    logic [NS-1:0]   hold_q, hold_d;
    logic [NS-1:0]   load_word;
    logic            hold_vld_q, hold_vld_d;
    logic            sd_d, ws_d, udr_d, ovf_d;
    logic            load;

    assign load_word = hold_vld_q ? hold_q : '0;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        frame_d    = frame_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sd_d       = out_sd;
        ws_d       = out_ws;
        udr_d      = 1'b0;
        ovf_d      = 1'b0;
        load       = 1'b0;

        if (sck_fall) begin
            if (state_q == IDLE) begin
                state_d = RUN;
                slot_d  = '0;
                load    = 1'b1;
            end else if (slot_q == SW'(NS - 1)) begin
                slot_d = '0;
                load   = 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end

            // Frame register is pre-shifted: its MSB is always the next slot's bit.
            if (load) begin
                sd_d       = load_word[NS-1];
                frame_d    = {load_word[NS-2:0], 1'b0};
                udr_d      = ~hold_vld_q;
                hold_vld_d = 1'b0;
            end else begin
                sd_d    = frame_q[NS-1];
                frame_d = {frame_q[NS-2:0], 1'b0};
            end

            ws_d = (slot_d >= SW'(BPW - 1)) && (slot_d <= SW'(NS - 2));
        end

        // A write coinciding with a load lands after the load has consumed holding.
        if (in_xfc) begin
            hold_d     = {in_lft, in_rgt};
            hold_vld_d = 1'b1;
            ovf_d      = hold_vld_q & ~load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !rf_i2so_en) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            frame_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            out_sd     <= 1'b0;
            out_ws     <= 1'b0;
            out_udr    <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            frame_q    <= frame_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            out_sd     <= sd_d;
            out_ws     <= ws_d;
            out_udr    <= udr_d;
            out_ovf    <= ovf_d;
        end
    end

    assign out_rdy = ~hold_vld_q;

endmodule

// File: tb/tb_i2so_serializer.sv
// tb/tb_i2so_serializer.sv - randomized self-checking bench for i2so_serializer
module tb_i2so_serializer;
    localparam int BPW = 16;
    localparam int NS  = 2 * BPW;

    logic           clk = 1'b0;
    logic           rst, sck_fall, rf_i2so_en, in_xfc;
    logic [BPW-1:0] in_lft, in_rgt;
    logic           out_sd, out_ws, out_rdy, out_udr, out_ovf;

    i2so_serializer #(.BPW(BPW)) dut (
        .clk(clk), .rst(rst), .sck_fall(sck_fall), .rf_i2so_en(rf_i2so_en),
        .in_lft(in_lft), .in_rgt(in_rgt), .in_xfc(in_xfc),
        .out_sd(out_sd), .out_ws(out_ws), .out_rdy(out_rdy),
        .out_udr(out_udr), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: which frame is on the wire, at which slot, and what is held.
    bit             m_run;
    int             m_slot;
    logic [BPW-1:0] m_cur_l, m_cur_r, m_hold_l, m_hold_r;
    bit             m_hold_vld, m_udr, m_ovf;
    int             since_sf;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit sf, input bit x,
                       input logic [BPW-1:0] l, input logic [BPW-1:0] rr);
        bit load, vld_before;
        int exp_sd, exp_ws;
        rst = r; rf_i2so_en = e; sck_fall = sf; in_xfc = x; in_lft = l; in_rgt = rr;
        @(posedge clk);
        if (r || !e) begin
            m_run = 0; m_slot = 0; m_cur_l = '0; m_cur_r = '0;
            m_hold_vld = 0; m_udr = 0; m_ovf = 0;
        end else begin
            load = 0;
            vld_before = m_hold_vld;
            if (sf) begin
                if (!m_run) begin
                    m_run = 1; m_slot = 0;
                end else begin
                    m_slot = (m_slot + 1) % NS;
                end
                load = (m_slot == 0);
            end
            m_udr = load && !vld_before;
            if (load) begin
                m_cur_l = vld_before ? m_hold_l : '0;
                m_cur_r = vld_before ? m_hold_r : '0;
                m_hold_vld = 0;
            end
            m_ovf = x && vld_before && !load;
            if (x) begin
                m_hold_l = l; m_hold_r = rr; m_hold_vld = 1;
            end
        end
        @(negedge clk);
        if (!m_run) begin
            exp_sd = 0; exp_ws = 0;
        end else begin
            exp_sd = (m_slot < BPW) ? int'(m_cur_l[BPW-1-m_slot]) : int'(m_cur_r[NS-1-m_slot]);
            exp_ws = (m_slot >= BPW - 1 && m_slot <= NS - 2) ? 1 : 0;
        end
        check_val("sd",  32'(out_sd),  32'(exp_sd));
        check_val("ws",  32'(out_ws),  32'(exp_ws));
        check_val("rdy", 32'(out_rdy), 32'(!m_hold_vld));
        check_val("udr", 32'(out_udr), 32'(m_udr));
        check_val("ovf", 32'(out_ovf), 32'(m_ovf));
    endtask

    task automatic strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 1, 0, '0, '0);
            for (int j = 1; j < gap; j++) cyc(0, 1, 0, 0, '0, '0);
        end
    endtask

    task automatic run_to_slot(input int s);
        for (int g = 0; g < 2 * NS && !(m_run && m_slot == s); g++) strobes(1, 3);
    endtask

    initial begin
        rst = 1; rf_i2so_en = 0; sck_fall = 0; in_xfc = 0; in_lft = '0; in_rgt = '0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) cyc(1, 1, 0, i[0], 16'h1234, 16'h5678);

        cyc(0, 1, 0, 1, 16'hAAAA, 16'hFFFF);
        cyc(0, 1, 0, 0, '0, '0);
        strobes(33, 80);
        strobes(32, 4);

        cyc(0, 1, 0, 1, 16'h1111, 16'h1111);
        cyc(0, 1, 0, 1, 16'h0001, 16'h0001);
        strobes(40, 3);

        cyc(0, 1, 0, 1, 16'h1478, 16'hA3B9);
        run_to_slot(NS - 1);
        cyc(0, 1, 1, 1, 16'hBEEF, 16'hCAFE);
        cyc(0, 1, 0, 0, '0, '0);
        strobes(34, 3);

        cyc(0, 1, 0, 1, 16'hCDD7, 16'hBABA);
        run_to_slot(7);
        cyc(0, 0, 0, 0, '0, '0);
        cyc(0, 0, 0, 1, 16'hDEAD, 16'hDEAD);
        cyc(0, 1, 0, 1, 16'h5A5A, 16'hA5A5);
        cyc(0, 1, 0, 0, '0, '0);
        strobes(35, 3);

        since_sf = 2;
        for (int i = 0; i < 6000; i++) begin
            bit sf, x, e, r;
            sf = (since_sf >= 2) && ($urandom_range(0, 2) == 0);
            x  = ($urandom_range(0, 29) == 0);
            e  = ($urandom_range(0, 1499) != 0);
            r  = ($urandom_range(0, 2999) == 0);
            since_sf = sf ? 1 : since_sf + 1;
            cyc(r, e, sf, x, BPW'($urandom), BPW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
